// File: rtl/mcu_playlist.sv
// mcu_playlist: playlist control unit. Sequences play/pause, next/prev and
// end-of-song events over NUM_SONGS entries under one of four end-of-song
// policies (sequential, repeat-all, repeat-one, shuffle).
module mcu_playlist #(
  parameter int NUM_SONGS = 4,
  parameter int SONG_W    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_pause,
  input  logic              next,
  input  logic              prev,
  input  logic              song_done,
  input  logic [1:0]        mode,
  output logic              play,
  output logic              reset_play,
  output logic [SONG_W-1:0] song
);

  localparam logic [2:0] ST_RESET   = 3'd0;
  localparam logic [2:0] ST_PAUSE   = 3'd1;
  localparam logic [2:0] ST_PLAY    = 3'd2;
  localparam logic [2:0] ST_ADV     = 3'd3;
  localparam logic [2:0] ST_RESTART = 3'd4;

  localparam logic [1:0] M_SEQ        = 2'b00;
  localparam logic [1:0] M_REPEAT_ALL = 2'b01;
  localparam logic [1:0] M_REPEAT_ONE = 2'b10;
  localparam logic [1:0] M_SHUFFLE    = 2'b11;

  localparam logic [SONG_W-1:0] LAST  = SONG_W'(NUM_SONGS - 1);
  localparam logic [SONG_W:0]   COUNT = (SONG_W + 1)'(NUM_SONGS);

  logic [2:0]        state, state_n;
  logic              resume, resume_n;
  logic [SONG_W-1:0] song_n;
  logic [SONG_W-1:0] fwd, bwd, cand, shuf, next_tgt;
  logic [7:0]        lfsr;
  logic              lfsr_fb;

  // Candidate targets: modulo-NUM_SONGS neighbours and the shuffle pick
  always_comb begin
    fwd      = (song == LAST) ? '0 : song + SONG_W'(1);
    bwd      = (song == '0) ? LAST : song - SONG_W'(1);
    cand     = lfsr[SONG_W-1:0];
    // An out-of-range or repeated candidate falls back to the forward
    // neighbour, so shuffle never replays the current song.
    shuf     = (({1'b0, cand} < COUNT) && (cand != song)) ? cand : fwd;
    next_tgt = (mode == M_SHUFFLE) ? shuf : fwd;
    lfsr_fb  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  end

  // Next-state decision: song index and resume flag are loaded on entry
  // to ADV/RESTART so they appear together with reset_play
  always_comb begin
    state_n  = state;
    song_n   = song;
    resume_n = resume;
    case (state)
      ST_RESET: state_n = ST_PAUSE;
      ST_PAUSE: begin
        if (next) begin
          state_n  = ST_ADV;
          song_n   = next_tgt;
          resume_n = 1'b0;
        end else if (prev) begin
          state_n  = ST_ADV;
          song_n   = bwd;
          resume_n = 1'b0;
        end else if (play_pause) begin
          state_n = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (next) begin
          state_n  = ST_ADV;
          song_n   = next_tgt;
          resume_n = 1'b1;
        end else if (prev) begin
          state_n  = ST_ADV;
          song_n   = bwd;
          resume_n = 1'b1;
        end else if (song_done) begin
          case (mode)
            M_SEQ: begin
              state_n  = ST_ADV;
              song_n   = fwd;
              resume_n = (song != LAST);
            end
            M_REPEAT_ALL: begin
              state_n  = ST_ADV;
              song_n   = fwd;
              resume_n = 1'b1;
            end
            M_REPEAT_ONE: begin
              state_n  = ST_RESTART;
              resume_n = 1'b1;
            end
            default: begin
              state_n  = ST_ADV;
              song_n   = shuf;
              resume_n = 1'b1;
            end
          endcase
        end else if (play_pause) begin
          state_n = ST_PAUSE;
        end
      end
      ST_ADV, ST_RESTART: state_n = resume ? ST_PLAY : ST_PAUSE;
      default: state_n = ST_RESET;
    endcase
  end

  // State, index, resume flag and free-running LFSR registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_RESET;
      song   <= '0;
      resume <= 1'b0;
      lfsr   <= 8'h01;
    end else begin
      state  <= state_n;
      song   <= song_n;
      resume <= resume_n;
      lfsr   <= {lfsr[6:0], lfsr_fb};
    end
  end

  // Moore output decode from the state register
  always_comb begin
    play       = (state == ST_PLAY);
    reset_play = (state == ST_RESET) || (state == ST_ADV) || (state == ST_RESTART);
  end

endmodule

// File: tb/tb_mcu_playlist.sv
// Self-checking bench for mcu_playlist: directed vector table, multi-cycle
// corner sequences, and randomized stimulus against a behavioural model.
module tb_mcu_playlist;

  logic       clk = 1'b0;
  logic       reset, play_pause, next, prev, song_done;
  logic [1:0] mode;
  logic       play4, rp4, play5, rp5;
  logic [1:0] song4;
  logic [2:0] song5;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mcu_playlist #(.NUM_SONGS(4), .SONG_W(2)) dut4 (
    .clk(clk), .reset(reset), .play_pause(play_pause), .next(next),
    .prev(prev), .song_done(song_done), .mode(mode),
    .play(play4), .reset_play(rp4), .song(song4)
  );

  mcu_playlist #(.NUM_SONGS(5), .SONG_W(3)) dut5 (
    .clk(clk), .reset(reset), .play_pause(play_pause), .next(next),
    .prev(prev), .song_done(song_done), .mode(mode),
    .play(play5), .reset_play(rp5), .song(song5)
  );

  // Player model: a stable playing/paused condition plus a one-cycle
  // "busy" window in which the song reader is being restarted.
  typedef struct {
    int song;
    bit playing;
    bit busy;
    int lfsr;
  } mst_t;

  mst_t m4, m5;

  function automatic mst_t mstep(mst_t s, int n, int w, bit r, bit p, bit nx,
                                 bit pv, bit sd, logic [1:0] md);
    mst_t o;
    int fwd, bwd, c, sh, tgt;
    o = s;
    if (r) begin
      o.song = 0; o.playing = 0; o.busy = 1; o.lfsr = 1;
      return o;
    end
    o.lfsr = ((s.lfsr << 1) | (((s.lfsr >> 7) ^ (s.lfsr >> 5) ^ (s.lfsr >> 4) ^ (s.lfsr >> 3)) & 1)) & 255;
    if (s.busy) begin
      o.busy = 0;
      return o;
    end
    fwd = (s.song + 1) % n;
    bwd = (s.song + n - 1) % n;
    c   = s.lfsr % (1 << w);
    sh  = (c < n && c != s.song) ? c : fwd;
    tgt = (md == 2'd3) ? sh : fwd;
    if (nx) begin
      o.song = tgt; o.busy = 1; o.playing = s.playing;
    end else if (pv) begin
      o.song = bwd; o.busy = 1; o.playing = s.playing;
    end else if (s.playing && sd) begin
      o.busy = 1;
      case (md)
        2'd0: begin o.song = fwd; o.playing = (s.song != n - 1); end
        2'd1: o.song = fwd;
        2'd2: o.song = s.song;
        default: o.song = sh;
      endcase
    end else if (p) begin
      o.playing = !s.playing;
    end
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock cycle with the given inputs; models advance on the same edge
  task automatic cyc(input bit r, input bit p, input bit nx, input bit pv,
                     input bit sd, input logic [1:0] md);
    reset = r; play_pause = p; next = nx; prev = pv; song_done = sd; mode = md;
    @(posedge clk);
    m4 = mstep(m4, 4, 2, r, p, nx, pv, sd, md);
    m5 = mstep(m5, 5, 3, r, p, nx, pv, sd, md);
    #1;
  endtask

  typedef struct {
    bit r, p, nx, pv, sd;
    logic [1:0] md;
    bit e_play, e_rp;
    int e_song;
  } vec_t;

  vec_t tbl[30];
  int seqa[200];
  int seqb[200];

  task automatic shuffle_run(input bit second);
    int old;
    cyc(1, 0, 0, 0, 0, 2'd3);
    cyc(0, 0, 0, 0, 0, 2'd3);
    cyc(0, 1, 0, 0, 0, 2'd3);
    chk("shuf_start_play", play4, 1);
    for (int k = 0; k < 200; k++) begin
      old = song4;
      cyc(0, 0, 0, 0, 1, 2'd3);
      chk($sformatf("shuf%0d_diff", k), song4 != old[1:0], 1);
      chk($sformatf("shuf%0d_rp", k), rp4, 1);
      chk($sformatf("shuf%0d_range5", k), song5 < 3'd5, 1);
      chk($sformatf("shuf%0d_model", k), song4, m4.song);
      if (second) seqb[k] = song4; else seqa[k] = song4;
      cyc(0, 0, 0, 0, 0, 2'd3);
      chk($sformatf("shuf%0d_play", k), play4, 1);
    end
  endtask

  initial begin
    m4 = '{0, 0, 0, 1};
    m5 = '{0, 0, 0, 1};

    //        r  p  nx pv sd md    play rp song
    tbl[0]  = '{1, 0, 0, 0, 0, 2'd0, 0, 1, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 2'd0, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 0, 0, 2'd0, 1, 0, 0};
    tbl[3]  = '{0, 0, 1, 0, 0, 2'd0, 0, 1, 1};
    tbl[4]  = '{0, 0, 0, 0, 0, 2'd0, 1, 0, 1};
    tbl[5]  = '{0, 0, 1, 0, 0, 2'd0, 0, 1, 2};
    tbl[6]  = '{0, 0, 0, 0, 0, 2'd0, 1, 0, 2};
    tbl[7]  = '{0, 0, 0, 0, 1, 2'd2, 0, 1, 2};
    tbl[8]  = '{0, 0, 0, 0, 0, 2'd2, 1, 0, 2};
    tbl[9]  = '{0, 0, 1, 0, 0, 2'd0, 0, 1, 3};
    tbl[10] = '{0, 0, 0, 0, 0, 2'd0, 1, 0, 3};
    tbl[11] = '{0, 0, 0, 0, 1, 2'd0, 0, 1, 0};
    tbl[12] = '{0, 0, 0, 0, 0, 2'd0, 0, 0, 0};
    tbl[13] = '{0, 0, 0, 0, 1, 2'd0, 0, 0, 0};
    tbl[14] = '{0, 1, 0, 0, 0, 2'd0, 1, 0, 0};
    tbl[15] = '{0, 0, 0, 1, 0, 2'd0, 0, 1, 3};
    tbl[16] = '{0, 0, 0, 0, 0, 2'd0, 1, 0, 3};
    tbl[17] = '{0, 0, 0, 0, 1, 2'd1, 0, 1, 0};
    tbl[18] = '{0, 0, 0, 0, 0, 2'd1, 1, 0, 0};
    tbl[19] = '{0, 0, 1, 0, 0, 2'd0, 0, 1, 1};
    tbl[20] = '{0, 1, 1, 0, 0, 2'd0, 1, 0, 1};
    tbl[21] = '{0, 1, 1, 1, 1, 2'd0, 0, 1, 2};
    tbl[22] = '{0, 0, 0, 0, 0, 2'd0, 1, 0, 2};
    tbl[23] = '{0, 1, 0, 0, 0, 2'd0, 0, 0, 2};
    tbl[24] = '{0, 0, 1, 0, 0, 2'd0, 0, 1, 3};
    tbl[25] = '{0, 0, 0, 0, 0, 2'd0, 0, 0, 3};
    tbl[26] = '{0, 1, 0, 0, 0, 2'd0, 1, 0, 3};
    tbl[27] = '{0, 0, 0, 1, 0, 2'd0, 0, 1, 2};
    tbl[28] = '{1, 0, 0, 0, 0, 2'd0, 0, 1, 0};
    tbl[29] = '{0, 0, 0, 0, 0, 2'd0, 0, 0, 0};

    for (int i = 0; i < 30; i++) begin
      cyc(tbl[i].r, tbl[i].p, tbl[i].nx, tbl[i].pv, tbl[i].sd, tbl[i].md);
      chk($sformatf("tbl%0d_play", i), play4, tbl[i].e_play);
      chk($sformatf("tbl%0d_rp", i), rp4, tbl[i].e_rp);
      chk($sformatf("tbl%0d_song", i), song4, tbl[i].e_song);
    end

    // Five-entry wrap-around while paused, then prev from index 0
    cyc(1, 0, 0, 0, 0, 2'd0);
    cyc(0, 0, 0, 0, 0, 2'd0);
    for (int k = 1; k <= 5; k++) begin
      cyc(0, 0, 1, 0, 0, 2'd0);
      chk($sformatf("wrap%0d_song", k), song5, k % 5);
      chk($sformatf("wrap%0d_rp", k), rp5, 1);
      chk($sformatf("wrap%0d_play", k), play5, 0);
      cyc(0, 0, 0, 0, 0, 2'd0);
      chk($sformatf("wrap%0d_rp_off", k), rp5, 0);
      chk($sformatf("wrap%0d_play_off", k), play5, 0);
    end
    cyc(0, 0, 0, 1, 0, 2'd0);
    chk("prev0_song", song5, 4);
    chk("prev0_rp", rp5, 1);
    cyc(0, 0, 0, 0, 0, 2'd0);
    chk("prev0_play", play5, 0);

    // Shuffle: two identical runs from reset must give the same sequence
    shuffle_run(0);
    shuffle_run(1);
    for (int k = 0; k < 200; k++)
      chk($sformatf("shuf%0d_repeat", k), seqb[k], seqa[k]);

    // Randomized stimulus against the model, both parameterizations
    begin
      logic [1:0] md;
      md = 2'd0;
      cyc(1, 0, 0, 0, 0, md);
      for (int k = 0; k < 3000; k++) begin
        if ($urandom_range(0, 19) == 0) md = 2'($urandom_range(0, 3));
        cyc($urandom_range(0, 299) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 3) == 0, md);
        chk("rnd4_play", play4, m4.playing && !m4.busy);
        chk("rnd4_rp", rp4, m4.busy);
        chk("rnd4_song", song4, m4.song);
        chk("rnd5_play", play5, m5.playing && !m5.busy);
        chk("rnd5_rp", rp5, m5.busy);
        chk("rnd5_song", song5, m5.song);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
